// File: rtl/alu_pkg.sv
// Shared types for pipelined_alu: opcode and FSM state encodings, shift-amount sizing.
package alu_pkg;

    localparam int unsigned OP_W          = 4;
    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLT  = 4'h5,
        OP_SLTU = 4'h6,
        OP_SLL  = 4'h7,
        OP_SRL  = 4'h8,
        OP_SRA  = 4'h9,
        OP_MUL  = 4'hA
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    // Bits of src_b used as shift amount (also sizes the multiplier step counter).
    function automatic int unsigned shamt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// done_c/product_c flag and carry the final product during the last step; product holds it afterwards.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             done_c,
    output logic [WIDTH-1:0] product_c,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CNT_W = shamt_width(WIDTH);

    logic             busy;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    assign product_c = acc + (mplier[0] ? mcand : '0);
    assign done_c    = busy && (count == CNT_W'(WIDTH - 1));
    assign product   = acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= product_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            if (done_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU with registered result; single-cycle ops plus optional iterative MUL.
// Define PIPELINED_ALU_MUL_EN to compile in the multiplier and its MUL/HOLD states.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o,
    output logic             illegal_o
);

    localparam int unsigned SHAMT_W = shamt_width(WIDTH);
`ifdef PIPELINED_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             free_c;
    logic             load_c;
    logic             load_mul_c;
    logic             alu_illegal_c;
    logic [WIDTH-1:0] alu_result_c;
    logic [WIDTH-1:0] mul_result_c;
    logic [TAG_W-1:0] mul_tag_c;
    logic [WIDTH-1:0] load_result_c;

    // Single-cycle datapath; undefined opcodes produce 0.
    function automatic logic [WIDTH-1:0] alu_exec(
        input logic [OP_W-1:0]  op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return WIDTH'($signed(a) < $signed(b));
            OP_SLTU: return WIDTH'(a < b);
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return WIDTH'($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    assign free_c        = !out_valid_o || out_ready_i;
    assign alu_result_c  = alu_exec(op_i, src_a_i, src_b_i);
    assign alu_illegal_c = (op_i > OP_SRA) && !(MUL_EN && (op_i == OP_MUL));
    assign load_result_c = load_mul_c ? mul_result_c : alu_result_c;

`ifdef PIPELINED_ALU_MUL_EN
    alu_state_e       state_q;
    alu_state_e       state_d;
    logic             mul_start_c;
    logic             mul_done_c;
    logic [WIDTH-1:0] mul_product_c;
    logic [WIDTH-1:0] mul_product;
    logic [TAG_W-1:0] mul_tag_q;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (mul_start_c),
        .src_a     (src_a_i),
        .src_b     (src_b_i),
        .done_c    (mul_done_c),
        .product_c (mul_product_c),
        .product   (mul_product)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mul_tag_q <= '0;
        end else if (mul_start_c) begin
            mul_tag_q <= tag_i;
        end
    end

    // HOLD takes the product parked in the multiplier accumulator.
    assign mul_result_c = (state_q == ST_HOLD) ? mul_product : mul_product_c;
    assign mul_tag_c    = mul_tag_q;

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        load_c      = 1'b0;
        load_mul_c  = 1'b0;
        mul_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_o = free_c;
                if (in_valid_i && free_c) begin
                    if (op_i == OP_MUL) begin
                        mul_start_c = 1'b1;
                        state_d     = ST_MUL;
                    end else begin
                        load_c = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done_c) begin
                    if (free_c) begin
                        load_c     = 1'b1;
                        load_mul_c = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (free_c) begin
                    load_c     = 1'b1;
                    load_mul_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
`else
    assign mul_result_c = '0;
    assign mul_tag_c    = '0;

    always_comb begin
        in_ready_o = free_c;
        load_c     = in_valid_i && free_c;
        load_mul_c = 1'b0;
    end
`endif

    // Output register: loads on completion, clears on a pop with nothing new.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
            tag_o       <= '0;
            zero_o      <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (load_c) begin
            out_valid_o <= 1'b1;
            result_o    <= load_result_c;
            tag_o       <= load_mul_c ? mul_tag_c : tag_i;
            zero_o      <= (load_result_c == '0);
            illegal_o   <= load_mul_c ? 1'b0 : alu_illegal_c;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed cases then a random stream against a queue model.
module tb_pipelined_alu;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 4;
`ifdef PIPELINED_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag_out;
    logic             zero;
    logic             illegal;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    exp_t sb[$];

    pipelined_alu #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .src_a_i     (src_a),
        .src_b_i     (src_b),
        .tag_i       (tag_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .tag_o       (tag_out),
        .zero_o      (zero),
        .illegal_o   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic, masked back to 32 bits.
    function automatic exp_t ref_alu(input logic [3:0] o, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        exp_t e;
        longint unsigned ua, ub, mask;
        longint sa, sb_;
        int sh;
        ua = 64'(a); ub = 64'(b); mask = 64'hFFFF_FFFF;
        sa = (ua >= 64'h8000_0000) ? longint'(ua) - 64'sh1_0000_0000 : longint'(ua);
        sb_ = (ub >= 64'h8000_0000) ? longint'(ub) - 64'sh1_0000_0000 : longint'(ub);
        sh = int'(ub % 32);
        e.tag = t;
        e.ill = 1'b0;
        case (o)
            4'h0: e.res = WIDTH'((ua + ub) & mask);
            4'h1: e.res = WIDTH'((ua + 64'h1_0000_0000 - ub) & mask);
            4'h2: e.res = a & b;
            4'h3: e.res = a | b;
            4'h4: e.res = a ^ b;
            4'h5: e.res = (sa < sb_) ? 1 : 0;
            4'h6: e.res = (ua < ub) ? 1 : 0;
            4'h7: e.res = WIDTH'((ua << sh) & mask);
            4'h8: e.res = WIDTH'(ua >> sh);
            4'h9: e.res = WIDTH'(longint'(sa >>> sh) & longint'(mask));
            4'hA: begin
                if (MUL_EN) e.res = WIDTH'((ua * ub) & mask);
                else begin e.res = '0; e.ill = 1'b1; end
            end
            default: begin e.res = '0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    // Offer one op (called mid-cycle); check acceptance and the result one edge later.
    task automatic do_single(input string name, input logic [3:0] o, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                             input logic [WIDTH-1:0] exp_res, input logic exp_ill);
        in_valid = 1'b1; op = o; src_a = a; src_b = b; tag_in = t;
        #1;
        check({name, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check({name, "_vld"}, 64'(out_valid), 64'd1);
        check({name, "_res"}, 64'(result), 64'(exp_res));
        check({name, "_tag"}, 64'(tag_out), 64'(t));
        check({name, "_zero"}, 64'(zero), 64'(exp_res == '0));
        check({name, "_ill"}, 64'(illegal), 64'(exp_ill));
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] exp_res,
                           input logic stall);
        int lat;
        out_ready = !stall;
        in_valid = 1'b1; op = 4'hA; src_a = a; src_b = b; tag_in = t;
        #1;
        check("mul_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            check("mul_busy_rdy", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("mul_latency", 64'(lat), 64'(WIDTH));
        check("mul_res", 64'(result), 64'(exp_res));
        check("mul_tag", 64'(tag_out), 64'(t));
        check("mul_ill", 64'(illegal), 64'd0);
        if (stall) begin
            repeat (3) begin
                @(posedge clk); #1;
                check("mul_hold_vld", 64'(out_valid), 64'd1);
                check("mul_hold_res", 64'(result), 64'(exp_res));
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("mul_popped", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic             stray;
        logic             prev_stall;
        logic [WIDTH-1:0] prev_res;
        logic [TAG_W-1:0] prev_tag;
        logic             prev_zero, prev_ill;
        exp_t             e;
        int               guard;

        rst = 1'b1; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0; tag_in = '0;
        out_ready = 1'b1;
        #12;
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_res", 64'(result), 64'd0);
        check("rst_tag", 64'(tag_out), 64'd0);
        check("rst_flags", 64'({zero, illegal}), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst_rdy", 64'(in_ready), 64'd1);

        // Back-to-back stream, one result per cycle
        do_single("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 4'd1, 32'h0, 1'b0);
        do_single("sub", 4'h1, 32'd3, 32'd5, 4'd2, 32'hFFFF_FFFE, 1'b0);
        do_single("slt", 4'h5, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1, 1'b0);
        do_single("sltu", 4'h6, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, 1'b0);
        do_single("sra", 4'h9, 32'h8000_0000, 32'h21, 4'd5, 32'hC000_0000, 1'b0);
        do_single("sll", 4'h7, 32'd1, 32'd31, 4'd6, 32'h8000_0000, 1'b0);
        do_single("ill_c", 4'hC, 32'd9, 32'd9, 4'd7, 32'h0, 1'b1);
        if (!MUL_EN) do_single("ill_mul", 4'hA, 32'd3, 32'd4, 4'd8, 32'h0, 1'b1);
        idle_cycle();
        check("drain_vld", 64'(out_valid), 64'd0);

        // Backpressure: result held, issue blocked, then pop+accept together
        out_ready = 1'b0;
        do_single("bp_add", 4'h0, 32'd7, 32'd8, 4'd9, 32'd15, 1'b0);
        in_valid = 1'b1; op = 4'h4; src_a = 32'hF0; src_b = 32'h0F; tag_in = 4'd10;
        repeat (5) begin
            #1;
            check("bp_rdy", 64'(in_ready), 64'd0);
            check("bp_vld", 64'(out_valid), 64'd1);
            check("bp_res", 64'(result), 64'd15);
            check("bp_tag", 64'(tag_out), 64'd9);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        do_single("bp_xor", 4'h4, 32'hF0, 32'h0F, 4'd10, 32'hFF, 1'b0);
        idle_cycle();

        if (MUL_EN) begin
            run_mul(32'h0001_0001, 32'h0001_0001, 4'd11, 32'h0002_0001, 1'b0);
            run_mul(32'hDEAD_BEEF, 32'h1234_5677, 4'd12,
                    ref_alu(4'hA, 32'hDEAD_BEEF, 32'h1234_5677, 4'd12).res, 1'b1);
        end

        // Reset in the middle of a (possibly multi-cycle) op
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'hA; src_a = 32'd6; src_b = 32'd7; tag_in = 4'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2; rst = 1'b1; #1;
        check("mid_rst_vld", 64'(out_valid), 64'd0);
        check("mid_rst_res", 64'(result), 64'd0);
        check("mid_rst_tag", 64'(tag_out), 64'd0);
        check("mid_rst_flags", 64'({zero, illegal}), 64'd0);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        stray = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            stray = stray | out_valid;
        end
        check("no_stray", 64'(stray), 64'd0);
        do_single("post_rst_add", 4'h0, 32'd2, 32'd3, 4'd14, 32'd5, 1'b0);
        idle_cycle();

        // Random stream against queue model
        prev_stall = 1'b0;
        prev_res = '0; prev_tag = '0; prev_zero = 1'b0; prev_ill = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (prev_stall) begin
                check("rnd_stable_vld", 64'(out_valid), 64'd1);
                check("rnd_stable", 64'({result, tag_out, zero, illegal}),
                      64'({prev_res, prev_tag, prev_zero, prev_ill}));
            end
            in_valid = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            if (op == 4'hA && $urandom_range(0, 3) != 0) op = 4'h0;
            src_a = (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom));
            src_b = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
            tag_in = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && !out_ready) check("rnd_rdy_stall", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rnd_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rnd_res", 64'(result), 64'(e.res));
                    check("rnd_tag", 64'(tag_out), 64'(e.tag));
                    check("rnd_zero", 64'(zero), 64'(e.res == '0));
                    check("rnd_ill", 64'(illegal), 64'(e.ill));
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_alu(op, src_a, src_b, tag_in));
            prev_stall = out_valid && !out_ready;
            prev_res = result; prev_tag = tag_out; prev_zero = zero; prev_ill = illegal;
            @(posedge clk); #1;
        end

        // Drain whatever is still in flight
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            #1;
            if (out_valid) begin
                e = sb.pop_front();
                check("drain_res", 64'(result), 64'(e.res));
                check("drain_tag", 64'(tag_out), 64'(e.tag));
            end
            @(posedge clk); #1;
            guard++;
        end
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
